// File: rtl/i2s_mic_slave_tx.sv
// rtl/i2s_mic_slave_tx.sv - I2S slave transmitter emulating an INMP441 microphone
//
// Ports:
//   clk, rst       system clock (>= 8x sck) and asynchronous active-high reset
//   sck, ws        bit clock and word select from the I2S master (async to clk)
//   lr             static slot select: 0 = left (ws=0), 1 = right (ws=1)
//   sample_in      sample word, accepted on sample_valid && sample_ready
//   sample_valid   sample_in is valid
//   sample_ready   holding register empty
//   sd, sd_oe      serial data and its output enable (pin is Z when sd_oe=0)
//   underrun       one-clk pulse when a slot starts with no new sample
//   busy           state machine not idle
module i2s_mic_slave_tx #(
    parameter int w_sample    = 24,
    parameter int sync_stages = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sck,
    input  logic                ws,
    input  logic                lr,
    input  logic [w_sample-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sd,
    output logic                sd_oe,
    output logic                underrun,
    output logic                busy
);

    localparam int cnt_w = $clog2(w_sample);

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

    state_t                state, state_n;
    logic [sync_stages-1:0] sck_sync, ws_sync;
    logic                  sck_s, ws_s, sck_d;
    logic                  sck_rise, sck_fall;
    logic                  ws_r, ws_p;
    logic                  slot_start, slot_match, accept;

    logic [w_sample-1:0]   hold, hold_n, last, last_n, shift, shift_n, load_word;
    logic                  hold_full, hold_full_n;
    logic [cnt_w-1:0]      bit_cnt, bit_cnt_n;
    logic                  sd_n, sd_oe_n, underrun_n;

    assign sck_s    = sck_sync[sync_stages-1];
    assign ws_s     = ws_sync[sync_stages-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    // A slot starts when the ws value about to be captured differs from the
    // one captured at the previous rising edge (i.e. new ws_r != new ws_p).
    assign slot_start = sck_rise && (ws_s != ws_r);
    assign slot_match = (ws_s == lr);

    assign sample_ready = ~hold_full;
    assign accept       = sample_valid & sample_ready;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sck_d    <= 1'b0;
            ws_r     <= 1'b0;
            ws_p     <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[sync_stages-2:0], sck};
            ws_sync  <= {ws_sync[sync_stages-2:0], ws};
            sck_d    <= sck_s;
            if (sck_rise) begin
                ws_r <= ws_s;
                ws_p <= ws_r;
            end
        end
    end

    always_comb begin
        state_n     = state;
        sd_n        = sd;
        sd_oe_n     = sd_oe;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        hold_n      = hold;
        hold_full_n = hold_full;
        last_n      = last;
        underrun_n  = 1'b0;
        load_word   = last;

        if (accept) begin
            hold_n      = sample_in;
            hold_full_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (slot_start && slot_match) begin
                    state_n = ARMED;
                end
                if (sck_fall) begin
                    sd_oe_n = 1'b0;
                    sd_n    = 1'b0;
                end
            end
            ARMED, SHIFT: begin
                if (slot_start) begin
                    // Short slot or re-armed before load: re-evaluate the new slot.
                    state_n = slot_match ? ARMED : IDLE;
                end else if (sck_fall && state == ARMED) begin
                    if (hold_full) begin
                        load_word   = hold;
                        hold_full_n = 1'b0;
                    end else if (sample_valid) begin
                        // Bypass: the accepted beat goes straight to the shifter.
                        load_word   = sample_in;
                        hold_n      = hold;
                        hold_full_n = 1'b0;
                    end else begin
                        load_word  = last;
                        underrun_n = 1'b1;
                    end
                    shift_n   = load_word;
                    last_n    = load_word;
                    sd_n      = load_word[w_sample-1];
                    sd_oe_n   = 1'b1;
                    bit_cnt_n = cnt_w'(w_sample - 1);
                    state_n   = SHIFT;
                end else if (sck_fall) begin
                    if (bit_cnt != '0) begin
                        shift_n   = shift << 1;
                        sd_n      = shift[w_sample-2];
                        bit_cnt_n = bit_cnt - cnt_w'(1);
                    end else begin
                        sd_oe_n = 1'b0;
                        sd_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sd        <= 1'b0;
            sd_oe     <= 1'b0;
            underrun  <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            last      <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
        end else begin
            state     <= state_n;
            sd        <= sd_n;
            sd_oe     <= sd_oe_n;
            underrun  <= underrun_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            last      <= last_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
        end
    end

endmodule

// File: tb/tb_i2s_mic_slave_tx.sv
// tb/tb_i2s_mic_slave_tx.sv - self-checking bench for i2s_mic_slave_tx
module tb_i2s_mic_slave_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck, ws, lr;
    logic [23:0] sample_in;
    logic        sample_valid;
    logic        sample_ready, sd, sd_oe, underrun, busy;

    int checks = 0;
    int errors = 0;
    int ur_total = 0;

    logic [23:0] cap_word [2];
    int          cap_n [2];
    int          oe_cnt [2];
    int          oe_bad [2];
    logic        busy_seen;
    int          bp_n;

    typedef struct {
        logic        lr;
        logic        push;
        logic [23:0] sample;
        logic [23:0] exp_word;
        int          exp_ur;
    } vec_t;

    vec_t vecs [7];

    i2s_mic_slave_tx #(.w_sample(24), .sync_stages(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ws(ws), .lr(lr),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sd(sd), .sd_oe(sd_oe),
        .underrun(underrun), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (underrun === 1'b1) ur_total <= ur_total + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [23:0] d);
        int n = 0;
        @(negedge clk);
        sample_in    = d;
        sample_valid = 1'b1;
        while (!sample_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) chk("push_timeout", n, 0);
        @(posedge clk);
        #1 sample_valid = 1'b0;
    endtask

    // Master model: ws changes with sck falling, sd sampled on sck rising.
    // Slot rise k=1 is the first rise after the ws change; data at k=2..25.
    task automatic run_frame(input int llen, input int rlen, input int rst_at);
        int len;
        for (int s = 0; s < 2; s++) begin
            cap_word[s] = '0; cap_n[s] = 0; oe_cnt[s] = 0; oe_bad[s] = 0;
        end
        busy_seen = 1'b0;
        for (int s = 0; s < 2; s++) begin
            len = (s == 0) ? llen : rlen;
            for (int k = 1; k <= len; k++) begin
                @(negedge clk);
                sck = 1'b0;
                ws  = (s == 1);
                repeat (7) @(negedge clk);
                @(negedge clk);
                sck = 1'b1;
                if (sd_oe) begin
                    oe_cnt[s]++;
                    if (k >= 2 && k <= 25) begin
                        cap_word[s] = {cap_word[s][22:0], sd};
                        cap_n[s]++;
                    end else begin
                        oe_bad[s]++;
                    end
                end
                if (busy) busy_seen = 1'b1;
                if (s == 0 && k == rst_at - 3) begin
                    sample_in    = 24'h222222;
                    sample_valid = 1'b1;
                    @(negedge clk);
                    sample_valid = 1'b0;
                    chk("hold_full_before_rst", sample_ready, 0);
                end
                if (s == 0 && k == rst_at) begin
                    rst = 1'b1;
                    #1;
                    chk("rst_sd_oe", sd_oe, 0);
                    chk("rst_sd", sd, 0);
                    chk("rst_ready", sample_ready, 1);
                    chk("rst_busy", busy, 0);
                    @(negedge clk);
                    rst = 1'b0;
                end
                repeat (7) @(negedge clk);
            end
        end
    endtask

    initial begin
        int own, ur0;

        vecs[0] = '{1'b0, 1'b1, 24'hA5F00F, 24'hA5F00F, 0};
        vecs[1] = '{1'b1, 1'b1, 24'h800001, 24'h800001, 0};
        vecs[2] = '{1'b1, 1'b1, 24'h123456, 24'h123456, 0};
        vecs[3] = '{1'b1, 1'b0, 24'h000000, 24'h123456, 1};
        vecs[4] = '{1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 0};
        vecs[5] = '{1'b0, 1'b1, 24'h000000, 24'h000000, 0};
        vecs[6] = '{1'b0, 1'b0, 24'h000000, 24'h000000, 1};

        rst = 1'b1; sck = 1'b1; ws = 1'b1; lr = 1'b0;
        sample_valid = 1'b0; sample_in = '0;
        repeat (4) @(negedge clk);
        chk("reset_sd", sd, 0);
        chk("reset_sd_oe", sd_oe, 0);
        chk("reset_ready", sample_ready, 1);
        chk("reset_underrun", underrun, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_reset_ready", sample_ready, 1);
        chk("post_reset_busy", busy, 0);

        // Preamble with ws=1 so the first left slot sees a real transition.
        run_frame(0, 4, 0);

        for (int i = 0; i < 7; i++) begin
            lr  = vecs[i].lr;
            own = int'(vecs[i].lr);
            ur0 = ur_total;
            if (vecs[i].push) push(vecs[i].sample);
            run_frame(32, 32, 0);
            chk($sformatf("v%0d_word", i), cap_word[own], vecs[i].exp_word);
            chk($sformatf("v%0d_oe_bits", i), oe_cnt[own], 24);
            chk($sformatf("v%0d_oe_outside", i), oe_bad[own], 0);
            chk($sformatf("v%0d_other_slot_oe", i), oe_cnt[1-own], 0);
            chk($sformatf("v%0d_underrun", i), ur_total - ur0, vecs[i].exp_ur);
            chk($sformatf("v%0d_ready", i), sample_ready, 1);
            chk($sformatf("v%0d_busy_seen", i), busy_seen, 1);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
        end

        // Backpressure: second beat stalls until the slot load frees hold.
        lr  = 1'b0;
        ur0 = ur_total;
        push(24'h000AAA);
        sample_in    = 24'h000555;
        sample_valid = 1'b1;
        @(negedge clk);
        chk("bp_stall_ready", sample_ready, 0);
        fork
            run_frame(32, 32, 0);
            begin
                bp_n = 0;
                while (!sample_ready && bp_n < 4000) begin
                    @(negedge clk);
                    bp_n++;
                end
                @(posedge clk);
                #1 sample_valid = 1'b0;
            end
        join
        chk("bp_stalled", (bp_n > 0 && bp_n < 4000), 1);
        chk("bp_frame1", cap_word[0], 24'h000AAA);
        run_frame(32, 32, 0);
        chk("bp_frame2", cap_word[0], 24'h000555);
        chk("bp_underrun", ur_total - ur0, 0);

        // Short slot: ws toggles after 16 bits of the own slot.
        ur0 = ur_total;
        push(24'hC3C3C3);
        run_frame(17, 32, 0);
        chk("short_bits", cap_n[0], 16);
        chk("short_word", cap_word[0][15:0], 16'hC3C3);
        chk("short_tail_oe", oe_cnt[1], 1);
        push(24'h3C3C3C);
        run_frame(32, 32, 0);
        chk("short_next_word", cap_word[0], 24'h3C3C3C);
        chk("short_next_oe", oe_cnt[0], 24);
        chk("short_underrun", ur_total - ur0, 0);

        // Reset after 10 bits; pending hold (0x222222) must be discarded.
        ur0 = ur_total;
        push(24'h111111);
        run_frame(32, 32, 11);
        chk("rst_bits", cap_n[0], 10);
        chk("rst_partial", cap_word[0][9:0], 10'h044);
        chk("rst_oe_total", oe_cnt[0] + oe_cnt[1], 10);
        push(24'h7FFFFF);
        run_frame(32, 32, 0);
        chk("rst_next_word", cap_word[0], 24'h7FFFFF);
        chk("rst_next_oe", oe_cnt[0], 24);
        chk("rst_underrun", ur_total - ur0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
